// File: rtl/aes_pkcs7_pad_pkg.sv
// Shared AES constants and the tkeep-to-byte-count helper used by the PKCS#7 padder.
package aes_pkcs7_pad_pkg;

   localparam int AES_BLOCK_SIZE   = 16;
   localparam int AES_WORD_BYTES   = 4;
   localparam int AES_BLOCK_WORDS  = AES_BLOCK_SIZE / AES_WORD_BYTES;
   localparam int AES128_KEY_BEATS = 4;
   localparam int AES192_KEY_BEATS = 6;
   localparam int AES256_KEY_BEATS = 8;

   // Valid byte count is the highest set tkeep bit plus one, so holes below it still count as data.
   function automatic logic [2:0] keep_to_count(input logic [3:0] keep);
      logic [2:0] cnt;
      if (keep[3])      cnt = 3'd4;
      else if (keep[2]) cnt = 3'd3;
      else if (keep[1]) cnt = 3'd2;
      else if (keep[0]) cnt = 3'd1;
      else              cnt = 3'd0;
      return cnt;
   endfunction

endpackage

// File: rtl/axis_if.sv
// 32-bit AXI-Stream bundle with byte keep, shared by the AES datapath blocks.
interface axis_if;

   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/aes_pkcs7_pad.sv
// Passes the key through, then applies PKCS#7 padding to the message so the ECB core
// always receives whole 16-byte blocks. One registered output stage with backpressure.
module aes_pkcs7_pad
   import aes_pkcs7_pad_pkg::*;
#(
   parameter int KEY_BEATS = AES128_KEY_BEATS
) (
   input logic    Clk,
   input logic    Rst,
   axis_if.slave  S_axis,
   axis_if.master M_axis
);

   typedef enum logic [1:0] {ST_KEY, ST_MSG, ST_PAD} state_t;

   state_t      state_q, state_d;
   logic [7:0]  key_cnt_q, key_cnt_d;
   logic [1:0]  w_q, w_d;
   logic [2:0]  pad_cnt_q, pad_cnt_d;
   logic [4:0]  pad_val_q, pad_val_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic [31:0] out_data_q, out_data_d;

   logic        ld;
   logic        s_ready;
   logic        s_acc;
   logic [2:0]  k;
   logic [4:0]  fill_total;
   logic [4:0]  pad_n;
   logic [31:0] fill_word;

   assign ld         = ~out_valid_q | M_axis.tready;
   assign s_ready    = ld & (state_q != ST_PAD) & ~Rst;
   assign s_acc      = s_ready & S_axis.tvalid;
   assign k          = keep_to_count(S_axis.tkeep);
   assign fill_total = {1'b0, w_q, 2'b00} + {2'b00, k};
   assign pad_n      = 5'(AES_BLOCK_SIZE) - {1'b0, fill_total[3:0]};

   assign S_axis.tready = s_ready;
   assign M_axis.tdata  = out_data_q;
   assign M_axis.tvalid = out_valid_q;
   assign M_axis.tlast  = out_last_q;
   assign M_axis.tkeep  = out_valid_q ? 4'hF : 4'h0;

   always_comb begin
      fill_word = S_axis.tdata;
      for (int j = 0; j < AES_WORD_BYTES; j++) begin
         if (3'(j) >= k) fill_word[8*j +: 8] = {3'b000, pad_n};
      end
   end

   always_comb begin
      state_d     = state_q;
      key_cnt_d   = key_cnt_q;
      w_d         = w_q;
      pad_cnt_d   = pad_cnt_q;
      pad_val_d   = pad_val_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         ST_KEY: begin
            if (s_acc) begin
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               out_data_d  = S_axis.tdata;
               if (key_cnt_q == 8'(KEY_BEATS - 1)) begin
                  key_cnt_d = '0;
                  w_d       = '0;
                  if (S_axis.tlast) begin
                     state_d   = ST_PAD;
                     pad_cnt_d = 3'd4;
                     pad_val_d = 5'(AES_BLOCK_SIZE);
                  end else begin
                     state_d = ST_MSG;
                  end
               end else begin
                  key_cnt_d = key_cnt_q + 8'd1;
               end
            end else if (ld) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end
         end
         ST_MSG: begin
            if (s_acc) begin
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               if (!S_axis.tlast) begin
                  out_data_d = S_axis.tdata;
                  w_d        = w_q + 2'd1;
               end else begin
                  out_data_d = fill_word;
                  pad_val_d  = pad_n;
                  w_d        = '0;
                  // A tlast word that exactly fills the block still needs a whole block of 0x10.
                  if (fill_total == 5'(AES_BLOCK_SIZE)) begin
                     pad_cnt_d = 3'd4;
                     state_d   = ST_PAD;
                  end else if (w_q == 2'd3) begin
                     out_last_d = 1'b1;
                     state_d    = ST_KEY;
                  end else begin
                     pad_cnt_d = {1'b0, 2'd3 - w_q};
                     state_d   = ST_PAD;
                  end
               end
            end else if (ld) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end
         end
         ST_PAD: begin
            if (ld) begin
               out_valid_d = 1'b1;
               out_data_d  = {4{3'b000, pad_val_q}};
               pad_cnt_d   = pad_cnt_q - 3'd1;
               out_last_d  = (pad_cnt_q == 3'd1);
               if (pad_cnt_q == 3'd1) state_d = ST_KEY;
            end
         end
         default: state_d = ST_KEY;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ST_KEY;
         key_cnt_q   <= '0;
         w_q         <= '0;
         pad_cnt_q   <= '0;
         pad_val_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         key_cnt_q   <= key_cnt_d;
         w_q         <= w_d;
         pad_cnt_q   <= pad_cnt_d;
         pad_val_q   <= pad_val_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_aes_pkcs7_pad.sv
// Scoreboard bench for aes_pkcs7_pad: directed frames, backpressure, mid-pad reset and
// random-length frames checked against a byte-level PKCS#7 model.
module tb_aes_pkcs7_pad;
   import aes_pkcs7_pad_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   axis_if s_if ();
   axis_if m_if ();

   aes_pkcs7_pad #(.KEY_BEATS(4)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .S_axis (s_if),
      .M_axis (m_if)
   );

   beat_t       in_q[$];
   exp_t        exp_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   bit          stall_en   = 1'b0;
   bit          held       = 1'b0;
   logic [31:0] held_data;
   logic        held_last;
   exp_t        e;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   // Sink readiness changes just after each rising edge so it is settled before sampling.
   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         m_if.tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: stability under stall, tkeep rules, and scoreboard pop on each transfer.
   always @(negedge Clk) begin
      if (held) begin
         checkOutput("stall_valid", 32'(m_if.tvalid), 32'd1);
         checkOutput("stall_data", m_if.tdata, held_data);
         checkOutput("stall_last", 32'(m_if.tlast), 32'(held_last));
      end
      held = 1'b0;
      if (m_if.tvalid === 1'b1) begin
         checkOutput("keep_valid", 32'(m_if.tkeep), 32'hF);
         if (m_if.tready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_beat", m_if.tdata, 32'hDEADDEAD);
            end else begin
               e = exp_q.pop_front();
               checkOutput("out_data", m_if.tdata, e.data);
               checkOutput("out_last", 32'(m_if.tlast), 32'(e.last));
            end
         end else if (!Rst) begin
            held      = 1'b1;
            held_data = m_if.tdata;
            held_last = m_if.tlast;
         end
      end else begin
         checkOutput("keep_idle", 32'(m_if.tkeep), 32'h0);
      end
   end

   task automatic pushBeat(input logic [31:0] d, input logic [3:0] kp, input logic l);
      beat_t b;
      b.data = d;
      b.keep = kp;
      b.last = l;
      in_q.push_back(b);
   endtask

   task automatic pushExp(input logic [31:0] d, input logic l);
      exp_t x;
      x.data = d;
      x.last = l;
      exp_q.push_back(x);
   endtask

   task automatic loadKey(input logic last_on_k3);
      for (int i = 0; i < 4; i++) begin
         pushBeat(32'hC0DE0000 | 32'(i), 4'hF, (i == 3) ? last_on_k3 : (i == 1));
         pushExp(32'hC0DE0000 | 32'(i), 1'b0);
      end
   endtask

   task automatic sendBeat(input beat_t b);
      int cycles = 0;
      bit acc = 1'b0;
      s_if.tdata  = b.data;
      s_if.tkeep  = b.keep;
      s_if.tlast  = b.last;
      s_if.tvalid = 1'b1;
      while (!acc && cycles < 1000) begin
         #1;
         acc = s_if.tready;
         @(posedge Clk);
         cycles++;
         @(negedge Clk);
      end
      if (!acc) checkOutput("s_accept_timeout", 32'd0, 32'd1);
      s_if.tvalid = 1'b0;
   endtask

   task automatic applyStimulus();
      while (in_q.size() != 0) sendBeat(in_q.pop_front());
   endtask

   task automatic waitDrain();
      int c = 0;
      while (exp_q.size() != 0 && c < 2000) begin
         @(negedge Clk);
         c++;
      end
      checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic frameShort();
      loadKey(1'b0);
      pushBeat(32'h44332211, 4'hF, 1'b0);
      pushBeat(32'hEEDDCC55, 4'h1, 1'b1);
      pushExp(32'h44332211, 1'b0);
      pushExp(32'h0B0B0B55, 1'b0);
      pushExp(32'h0B0B0B0B, 1'b0);
      pushExp(32'h0B0B0B0B, 1'b1);
   endtask

   task automatic runDirected();
      loadKey(1'b0);
      for (int i = 0; i < 4; i++) begin
         pushBeat(32'h03020100 + 32'(i) * 32'h04040404, (i == 0) ? 4'h0 : 4'hF, i == 3);
         pushExp(32'h03020100 + 32'(i) * 32'h04040404, 1'b0);
      end
      for (int i = 0; i < 4; i++) pushExp(32'h10101010, i == 3);
      frameShort();
      loadKey(1'b1);
      for (int i = 0; i < 4; i++) pushExp(32'h10101010, i == 3);
      loadKey(1'b0);
      pushBeat(32'h03020100, 4'hF, 1'b0);
      pushBeat(32'h07060504, 4'hF, 1'b0);
      pushBeat(32'h0B0A0908, 4'hF, 1'b0);
      pushBeat(32'hFF0E0D0C, 4'h7, 1'b1);
      pushExp(32'h03020100, 1'b0);
      pushExp(32'h07060504, 1'b0);
      pushExp(32'h0B0A0908, 1'b0);
      pushExp(32'h010E0D0C, 1'b1);
      loadKey(1'b0);
      pushBeat(32'h12345678, 4'hF, 1'b0);
      pushBeat(32'hA5A5A5A5, 4'h0, 1'b1);
      pushExp(32'h12345678, 1'b0);
      pushExp(32'h0C0C0C0C, 1'b0);
      pushExp(32'h0C0C0C0C, 1'b0);
      pushExp(32'h0C0C0C0C, 1'b1);
      loadKey(1'b0);
      pushBeat(32'h99887766, 4'h5, 1'b1);
      pushExp(32'h0D887766, 1'b0);
      for (int i = 0; i < 3; i++) pushExp(32'h0D0D0D0D, i == 2);
      applyStimulus();
      waitDrain();
   endtask

   // Byte-level PKCS#7 reference: message bytes plus N copies of N, grouped into words.
   task automatic runRandom(input int frames);
      logic [7:0]  msg[$];
      logic [31:0] d;
      logic [3:0]  kp;
      int len, nfull, r, n;
      bit extra0;
      for (int f = 0; f < frames; f++) begin
         msg.delete();
         len    = $urandom_range(0, 40);
         extra0 = (len % 4 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
         for (int i = 0; i < 4; i++) begin
            d = $urandom;
            pushBeat(d, 4'($urandom), (i == 3) ? (len == 0 && !extra0) : 1'($urandom_range(0, 1)));
            pushExp(d, 1'b0);
         end
         nfull = len / 4;
         r     = len % 4;
         for (int b = 0; b < nfull; b++) begin
            d = {msg[4*b+3], msg[4*b+2], msg[4*b+1], msg[4*b]};
            if (r == 0 && !extra0 && b == nfull - 1) pushBeat(d, 4'hF, 1'b1);
            else pushBeat(d, 4'($urandom), 1'b0);
         end
         if (r != 0) begin
            d = $urandom;
            for (int j = 0; j < r; j++) d[8*j +: 8] = msg[4*nfull+j];
            kp = (4'($urandom) & ((4'b1 << (r - 1)) - 4'b1)) | (4'b1 << (r - 1));
            pushBeat(d, kp, 1'b1);
         end
         if (extra0) pushBeat($urandom, 4'h0, 1'b1);
         n = 16 - (len % 16);
         for (int i = 0; i < n; i++) msg.push_back(8'(n));
         for (int wd = 0; wd < msg.size() / 4; wd++)
            pushExp({msg[4*wd+3], msg[4*wd+2], msg[4*wd+1], msg[4*wd]}, wd == msg.size() / 4 - 1);
      end
      applyStimulus();
      waitDrain();
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      checkOutput("rst_m_valid", 32'(m_if.tvalid), 32'd0);
      checkOutput("rst_m_keep", 32'(m_if.tkeep), 32'h0);
      checkOutput("rst_m_last", 32'(m_if.tlast), 32'd0);
      checkOutput("rst_m_data", m_if.tdata, 32'h0);
      checkOutput("rst_s_ready", 32'(s_if.tready), 32'd0);
      @(negedge Clk);
      Rst = 1'b0;

      stall_en = 1'b0;
      runDirected();
      stall_en = 1'b1;
      runDirected();

      // Reset lands while the padder is generating pad words for an empty message.
      stall_en = 1'b0;
      repeat (3) @(negedge Clk);
      loadKey(1'b1);
      applyStimulus();
      Rst = 1'b1;
      #1;
      checkOutput("rst_mid_s_ready", 32'(s_if.tready), 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      checkOutput("rst_abandon_valid", 32'(m_if.tvalid), 32'd0);
      checkOutput("rst_abandon_queue", 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge Clk);
      frameShort();
      applyStimulus();
      waitDrain();

      stall_en = 1'b1;
      runRandom(25);
      stall_en = 1'b0;
      repeat (3) @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/aes_pkcs7_pad.md
AES_PKCS7_PAD -- requirements
Module: aes_pkcs7_pad

Interface
REQ-001 The block SHALL have parameter KEY_BEATS, default 4, the number of 32-bit key beats that lead each frame (4 for AES-128).
REQ-002 The block SHALL have port Clk, input, 1 bit, the clock.
REQ-003 The block SHALL have port Rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port S_axis, axis_if.slave, 32-bit tdata with 4-bit tkeep, tvalid, tready and tlast, carrying the key then the raw message bytes.
REQ-005 The block SHALL have port M_axis, axis_if.master, 32-bit tdata with 4-bit tkeep, tvalid, tready and tlast, carrying the key then the padded plaintext to the AES ECB core.

Function
REQ-006 Input frame SHALL be KEY_BEATS key beats, then zero or more message beats; tlast SHALL mark the final beat of the frame; byte 0 of each beat SHALL be tdata[7:0].
REQ-007 The block SHALL forward key beats unchanged, with output tlast=0.
REQ-008 Input tlast on key beats 0..KEY_BEATS-2 SHALL be ignored.
REQ-009 Input tkeep on beats without tlast SHALL be ignored and treated as 4'hF.
REQ-010 On the tlast beat, the valid byte count k (0..4) SHALL be the index of the highest set tkeep bit plus 1, with tkeep=0 giving k=0.
REQ-011 Word index w (0..3) SHALL count message words modulo 4, reset at the start of each frame.
REQ-012 Pad value SHALL be N = 16 - ((4w+k) mod 16), so N is in 1..16.
REQ-013 On the last message beat, output bytes j<k SHALL be the input data and bytes j>=k SHALL be N.
REQ-014 After the last message beat, the block SHALL emit 3-w words of {4{N}}; if 4w+k=16 it SHALL instead emit 4 words of 32'h10101010.
REQ-015 Input tlast on key beat KEY_BEATS-1 (empty message) SHALL cause the block to emit the key beat with tlast=0, then 4 words of 32'h10101010.
REQ-016 Output tlast SHALL be 1 only on the final word of each padded block sequence.
REQ-017 Output tkeep SHALL always be 4'hF when tvalid=1, and 4'h0 otherwise.
REQ-018 State machine states SHALL be ST_KEY, ST_MSG and ST_PAD.
REQ-019 ST_KEY SHALL go to ST_MSG on acceptance of key beat KEY_BEATS-1 without tlast, or to ST_PAD with it.
REQ-020 ST_MSG SHALL go to ST_PAD on tlast when pad words remain, or to ST_KEY when the tlast word completes the block.
REQ-021 ST_PAD SHALL go to ST_KEY when the final pad word is loaded into the output register.
REQ-022 The output SHALL be a single registered stage, giving 1-cycle latency from input acceptance to M_axis.tvalid.
REQ-023 M_axis tdata, tlast and tvalid SHALL be held stable while tvalid=1 and tready=0.
REQ-024 Load enable SHALL be ld = ~out_valid | M_axis.tready.
REQ-025 S_axis.tready SHALL equal ld in ST_KEY and ST_MSG, and 0 in ST_PAD.
REQ-026 In ST_PAD, the block SHALL generate one pad word per cycle in which ld=1.
REQ-027 Full throughput of one beat per cycle SHALL be sustained while M_axis.tready=1; there is no bubble between frames except the pad words.

Reset
REQ-028 On Rst, the block SHALL set state ST_KEY and clear key counter, w, pad counter, out_valid, M_axis.tlast and output data, all to 0.
REQ-029 Rst SHALL take priority over any handshake; a frame in flight SHALL be abandoned with no further output beats.
REQ-030 S_axis.tready SHALL be 0 during the reset cycle.

Structure
REQ-031 AES_BLOCK_SIZE and key-size constants SHALL come from the shared aes_defines header/package; the state enum SHALL be local to the module.
REQ-032 No sub-module is required; the byte-fill mux SHALL be inline logic.

Verification
REQ-033 Key K0..K3, then 16 bytes in 4 full beats with tlast on the 4th -> 8 words passed unchanged, then 4x 32'h10101010, tlast only on the 12th output beat.
REQ-034 Key, then 32'h44332211 (keep F), then 32'h00000055 (keep 1, tlast) -> key, 32'h44332211, 32'h0B0B0B55, 32'h0B0B0B0B, 32'h0B0B0B0B with tlast on the last.
REQ-035 Key with tlast on K3 -> K0..K3 with tlast=0, then 4x 32'h10101010 with tlast on the 4th.
REQ-036 15-byte message (3 full beats, last beat keep 4'h7) -> last word 32'h01 in byte 3 with data in bytes 0..2, tlast=1, no extra words.
REQ-037 Random M_axis.tready stalls with 50% duty -> output sequence identical to the no-stall run, tdata stable during stalls, no loss or duplication.
REQ-038 Rst asserted in ST_PAD -> M_axis.tvalid=0 the next cycle; the following frame SHALL be padded correctly from w=0.
